// File: rtl/irq_arb_pkg.sv
// Shared definitions for the 6809 interrupt arbiter: register map, vector
// register bit positions and the interrupt line type.
package irq_arb_pkg;

  // Register addresses within the arbiter's I/O window
  localparam logic [1:0] ADDR_PEND  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_ROUTE = 2'd2;
  localparam logic [1:0] ADDR_VEC   = 2'd3;

  // Vector register layout: {valid, line, 3'b0, idx[2:0]}
  localparam int unsigned VEC_VALID   = 7;
  localparam int unsigned VEC_LINE    = 6;
  localparam int unsigned VEC_IDX_MSB = 2;
  localparam int unsigned VEC_IDX_LSB = 0;

  typedef enum logic {
    LINE_IRQ  = 1'b0,
    LINE_FIRQ = 1'b1
  } line_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request bit is set and the
// index of the lowest set bit (index 0 = highest priority).
// Ports:
//   req_i  N-bit request vector
//   any_o  at least one request set
//   idx_o  index of the lowest set request (0 when none)
module irq_prio_enc #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] req_i,
  output logic         any_o,
  output logic [2:0]   idx_o
);

  always_comb begin
    any_o = |req_i;
    idx_o = 3'd0;
    // Walk from the top down so the lowest set index is written last
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter for the 6809: synchronises active-low sources, keeps
// pending bits, applies mask and IRQ/FIRQ routing, and exposes a vector
// register whose read claims the winning source for its line until EOI.
// Optional feature macro: IRQ_EDGE_LATCH_EN
//   defined   - pending bits are sticky, set on a synchronised falling edge,
//               cleared by write-1-to-clear
//   undefined - pending bits follow the synchronised request level
// Ports:
//   i_eclk      E clock, all state on rising edge
//   i_reset_n   synchronous active-low reset
//   i_cs_n      register select, active low
//   i_rw        1 = read, 0 = write
//   i_addr      register address (PEND, MASK, ROUTE, VEC)
//   i_data      write data
//   o_data      read data, 0x00 unless a read is selected
//   i_src_n     asynchronous active-low interrupt requests
//   o_irq_n     registered IRQ_n to CPU
//   o_firq_n    registered FIRQ_n to CPU
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int unsigned NSRC        = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            i_eclk,
  input  logic            i_reset_n,
  input  logic            i_cs_n,
  input  logic            i_rw,
  input  logic [1:0]      i_addr,
  input  logic [7:0]      i_data,
  output logic [7:0]      o_data,
  input  logic [NSRC-1:0] i_src_n,
  output logic            o_irq_n,
  output logic            o_firq_n
);

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] src_lvl;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask_q, mask_d, route_q, route_d;
  logic            irq_busy_q, irq_busy_d, firq_busy_q, firq_busy_d;
  logic            irq_n_q, firq_n_q;
  logic [NSRC-1:0] act_irq, act_firq;
  logic            irq_any, firq_any;
  logic [2:0]      irq_idx, firq_idx;
  logic            wr_en, rd_en, vec_rd;
  logic            vec_valid;
  line_e           win_line;
  logic [2:0]      win_idx;
  logic [7:0]      vec_val, pend8, mask8, route8;
  logic            unused_data;

  assign unused_data = ^i_data;

  assign wr_en  = ~i_cs_n & ~i_rw;
  assign rd_en  = ~i_cs_n & i_rw;
  assign vec_rd = rd_en & (i_addr == ADDR_VEC);

  // Request synchroniser, idles high
  always_ff @(posedge i_eclk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= i_src_n;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign src_lvl = ~sync_q[SYNC_STAGES-1];

`ifdef IRQ_EDGE_LATCH_EN
  logic [NSRC-1:0] prev_q, pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (wr_en && (i_addr == ADDR_PEND)) pend_d = pend_d & ~i_data[NSRC-1:0];
    // Applied after the clear so a new edge wins over a same-edge W1C
    pend_d = pend_d | (prev_q & src_lvl);
  end

  always_ff @(posedge i_eclk) begin
    if (!i_reset_n) begin
      prev_q <= '1;
      pend_q <= '0;
    end else begin
      prev_q <= sync_q[SYNC_STAGES-1];
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = src_lvl;
`endif

  assign act_irq  = pend & mask_q & ~route_q;
  assign act_firq = pend & mask_q & route_q;

  irq_prio_enc #(.N(NSRC)) u_enc_irq (
    .req_i (act_irq),
    .any_o (irq_any),
    .idx_o (irq_idx)
  );

  irq_prio_enc #(.N(NSRC)) u_enc_firq (
    .req_i (act_firq),
    .any_o (firq_any),
    .idx_o (firq_idx)
  );

  // A line with a full slot is not eligible, so a busy IRQ never blocks FIRQ
  always_comb begin
    vec_valid = 1'b0;
    win_line  = LINE_IRQ;
    win_idx   = 3'd0;
    if (firq_any && !firq_busy_q) begin
      vec_valid = 1'b1;
      win_line  = LINE_FIRQ;
      win_idx   = firq_idx;
    end else if (irq_any && !irq_busy_q) begin
      vec_valid = 1'b1;
      win_line  = LINE_IRQ;
      win_idx   = irq_idx;
    end
    vec_val = 8'h00;
    if (vec_valid) begin
      vec_val[VEC_VALID]                   = 1'b1;
      vec_val[VEC_LINE]                    = (win_line == LINE_FIRQ);
      vec_val[VEC_IDX_MSB:VEC_IDX_LSB]     = win_idx;
    end
  end

  always_comb begin
    mask_d      = mask_q;
    route_d     = route_q;
    irq_busy_d  = irq_busy_q;
    firq_busy_d = firq_busy_q;
    if (vec_rd && vec_valid) begin
      if (win_line == LINE_FIRQ) firq_busy_d = 1'b1;
      else                       irq_busy_d  = 1'b1;
    end
    if (wr_en) begin
      unique case (i_addr)
        ADDR_MASK:  mask_d  = i_data[NSRC-1:0];
        ADDR_ROUTE: route_d = i_data[NSRC-1:0];
        ADDR_VEC: begin
          if (i_data[VEC_LINE]) firq_busy_d = 1'b0;
          else                  irq_busy_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_eclk) begin
    if (!i_reset_n) begin
      mask_q      <= '0;
      route_q     <= '0;
      irq_busy_q  <= 1'b0;
      firq_busy_q <= 1'b0;
      irq_n_q     <= 1'b1;
      firq_n_q    <= 1'b1;
    end else begin
      mask_q      <= mask_d;
      route_q     <= route_d;
      irq_busy_q  <= irq_busy_d;
      firq_busy_q <= firq_busy_d;
      irq_n_q     <= ~(irq_any & ~irq_busy_q);
      firq_n_q    <= ~(firq_any & ~firq_busy_q);
    end
  end

  assign o_irq_n  = irq_n_q;
  assign o_firq_n = firq_n_q;

  always_comb begin
    pend8  = 8'h00;
    mask8  = 8'h00;
    route8 = 8'h00;
    pend8[NSRC-1:0]  = pend;
    mask8[NSRC-1:0]  = mask_q;
    route8[NSRC-1:0] = route_q;
    o_data = 8'h00;
    if (rd_en) begin
      unique case (i_addr)
        ADDR_PEND:  o_data = pend8;
        ADDR_MASK:  o_data = mask8;
        ADDR_ROUTE: o_data = route8;
        ADDR_VEC:   o_data = vec_val;
        default:    o_data = 8'h00;
      endcase
    end
  end

endmodule
